regfile_port_ctrl: RTL and testbench
====================================

// Module: regfile_port_ctrl
// PURPOSE
//  Owns the single write port of the 32x32 register file. Merges pipeline writeback,
//  a buffered debug/host loader and a clear sequencer into one registered write stream.
//  Sits between the datapath/debug unit and the register file's WE/WrReg/InData.
//  Pipeline writeback always wins; debug waits in a FIFO; clear stalls the pipeline.
// PARAMETERS
//  ADDR_W     5   register address width
//  DATA_W     32  register data width
//  NUM_REGS   32  registers walked by clear (addresses 1..NUM_REGS-1)
//  FIFO_DEPTH 2   debug write FIFO entries (power of 2, >=2)
//  CLR_VALUE  0   data written to every register by clear
// PORTS
//  clock        in  1       rising-edge clock
//  reset        in  1       asynchronous, active-high
//  wb_we        in  1       pipeline writeback request; never back-pressured
//  wb_addr      in  ADDR_W  writeback register
//  wb_data      in  DATA_W  writeback data
//  dbg_valid    in  1       debug write offered
//  dbg_ready    out 1       debug FIFO can accept (= !full)
//  dbg_addr     in  ADDR_W  debug write register
//  dbg_data     in  DATA_W  debug write data
//  clr_start    in  1       one-cycle pulse: clear all registers
//  clr_busy     out 1       clear in progress
//  clr_done     out 1       one-cycle pulse when clear completes
//  pipe_stall   out 1       pipeline must hold (equals clr_busy)
//  wb_lost      out 1       sticky: wb_we seen while clr_busy; cleared by reset only
//  rf_we        out 1       to register file WE
//  rf_wr_reg    out ADDR_W  to register file WrReg
//  rf_in_data   out DATA_W  to register file InData
// BEHAVIOUR
//  - Reset: state IDLE, FIFO empty, rf_we=0, rf_wr_reg=0, rf_in_data=0, clr_busy=0,
//    clr_done=0, wb_lost=0, dbg_ready=1. Reset mid-clear aborts; no clr_done pulse.
//  - rf_* registered: a source selected in cycle N drives rf_we=1 in cycle N+1; rf_we=0
//    otherwise (rf_wr_reg/rf_in_data hold last value when rf_we=0).
//  - Priority per cycle in IDLE: wb_we > FIFO head. Writes to address 0 are consumed
//    (FIFO pops / wb accepted) but never produce rf_we.
//  - FIFO: push when dbg_valid && dbg_ready; pop when head selected. dbg_ready from
//    current occupancy only (no pass-through when full). Push+pop same cycle legal when
//    not full. Continuous wb_we may starve debug indefinitely; accepted.
//  - FSM: IDLE -> CLEAR on clr_start. CLEAR: counter 1..NUM_REGS-1, one rf write of
//    CLR_VALUE per cycle; after address NUM_REGS-1 issued -> DONE. DONE: clr_done=1 for
//    one cycle -> IDLE. clr_busy=1 in CLEAR and DONE; last rf_we of clear coincides with DONE.
//  - clr_start in CLEAR/DONE ignored. During CLEAR/DONE: wb_we dropped and sets wb_lost;
//    FIFO neither pops nor flushes but still accepts pushes; drains after return to IDLE.
//  - Clear of NUM_REGS=32 takes 31 write cycles; clr_done 32 cycles after clr_start.
// STRUCTURE
//  - Shared include regfile_defs.vh: ADDR_W/DATA_W/NUM_REGS defaults, FSM state encodings
//    (IDLE=2'd0, CLEAR=2'd1, DONE=2'd2), source select codes.
//  - One sub-module: regfile_wr_fifo (synchronous FIFO, async reset, full/empty flags,
//    {addr,data} entries). Arbiter, FSM and output register stay in this module.
// TESTING
//  1. wb_we addr=3 data=0x1234 -> next cycle rf_we=1, rf_wr_reg=3, rf_in_data=0x1234.
//  2. wb_we held 4 cycles while dbg pushes addr=5,6 then addr=7 -> dbg_ready=0 after 2 pushes;
//     after wb drops, rf writes 5 then 6 on consecutive cycles, then 7 accepted.
//  3. wb_we addr=0 and dbg write addr=0 -> both consumed, rf_we never asserted.
//  4. clr_start -> clr_busy/pipe_stall=1, rf writes addr 1..31 data 0 in order,
//     clr_done pulse 32 cycles later, then pending FIFO entries drain.
//  5. wb_we during clear -> no rf write for it, wb_lost=1 and stays 1 until reset.
//  6. reset asserted at clear address 10 -> outputs to reset values immediately, no clr_done.

Source files
------------

// File: rtl/regfile_port_ctrl_pkg.sv
// Shared constants for the register-file write-port controller.
// FSM encodings, write-source select codes and parameter defaults.
package regfile_port_ctrl_pkg;

    localparam int ADDR_W_DEF     = 5;
    localparam int DATA_W_DEF     = 32;
    localparam int NUM_REGS_DEF   = 32;
    localparam int FIFO_DEPTH_DEF = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_WB   = 2'd1;
    localparam logic [1:0] SRC_FIFO = 2'd2;
    localparam logic [1:0] SRC_CLR  = 2'd3;

endpackage

// File: rtl/regfile_port_ctrl_if.sv
// Bundle between datapath/debug sources and the register-file write port.
// master: request side; slave: the port controller.
interface regfile_port_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);

    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              dbg_valid;
    logic              dbg_ready;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    logic              pipe_stall;
    logic              wb_lost;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wr_reg;
    logic [DATA_W-1:0] rf_in_data;

    modport master (
        output wb_we, wb_addr, wb_data,
        output dbg_valid, dbg_addr, dbg_data,
        output clr_start,
        input  dbg_ready, clr_busy, clr_done,
        input  pipe_stall, wb_lost,
        input  rf_we, rf_wr_reg, rf_in_data
    );

    modport slave (
        input  wb_we, wb_addr, wb_data,
        input  dbg_valid, dbg_addr, dbg_data,
        input  clr_start,
        output dbg_ready, clr_busy, clr_done,
        output pipe_stall, wb_lost,
        output rf_we, rf_wr_reg, rf_in_data
    );

endinterface

// File: rtl/regfile_port_ctrl_wr_fifo.sv
// Small synchronous FIFO buffering debug/host register writes.
// Entries are {addr,data}; pointers carry a wrap bit for full/empty.
module regfile_wr_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PtrOne = {{PW{1'b0}}, 1'b1};

    logic [PW:0]      wrPtr;
    logic [PW:0]      rdPtr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             doPush;
    logic             doPop;

    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[PW] != rdPtr[PW]) &&
                   (wrPtr[PW-1:0] == rdPtr[PW-1:0]);

    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    assign headData = mem[rdPtr[PW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PtrOne;
            if (doPop)  rdPtr <= rdPtr + PtrOne;
        end
    end

    // Storage needs no reset: empty flag guards every read.
    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr[PW-1:0]] <= pushData;
    end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Single write port of the register file: arbitrates writeback,
// buffered debug writes and a clear sequencer into one registered stream.
module regfile_port_ctrl
    import regfile_port_ctrl_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
    input logic clock,
    input logic reset,
    regfile_port_ctrl_if.slave bus
);

    localparam int EW = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(NUM_REGS - 1);

    logic [1:0]        state;
    logic [1:0]        stateNext;
    logic [ADDR_W-1:0] clrAddr;
    logic [ADDR_W-1:0] clrAddrNext;

    logic              fifoFull;
    logic              fifoEmpty;
    logic              fifoPush;
    logic              fifoPop;
    logic [EW-1:0]     fifoHead;
    logic [ADDR_W-1:0] headAddr;
    logic [DATA_W-1:0] headData;

    logic [1:0]        src;
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;

    logic              busy;
    logic              rfWe;
    logic [ADDR_W-1:0] rfWrReg;
    logic [DATA_W-1:0] rfInData;
    logic              wbLost;

    assign busy = (state == ST_CLEAR) || (state == ST_DONE);

    assign fifoPush = bus.dbg_valid && !fifoFull;
    assign fifoPop  = (src == SRC_FIFO);
    assign headAddr = fifoHead[EW-1:DATA_W];
    assign headData = fifoHead[DATA_W-1:0];

    regfile_wr_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifoPush),
        .pushData ({bus.dbg_addr, bus.dbg_data}),
        .pop      (fifoPop),
        .headData (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    // Writeback beats the FIFO head; nothing but the sequencer runs in clear.
    always_comb begin
        src = SRC_NONE;
        unique case (1'b1)
            (state == ST_CLEAR):
                src = SRC_CLR;
            (state == ST_IDLE) && bus.wb_we:
                src = SRC_WB;
            (state == ST_IDLE) && !bus.wb_we && !fifoEmpty:
                src = SRC_FIFO;
            default:
                src = SRC_NONE;
        endcase
    end

    always_comb begin
        wrAddr = '0;
        wrData = '0;
        unique case (src)
            SRC_WB: begin
                wrAddr = bus.wb_addr;
                wrData = bus.wb_data;
            end
            SRC_FIFO: begin
                wrAddr = headAddr;
                wrData = headData;
            end
            SRC_CLR: begin
                wrAddr = clrAddr;
                wrData = CLR_VALUE;
            end
            default: begin
                wrAddr = '0;
                wrData = '0;
            end
        endcase
    end

    // Register 0 is hardwired: its writes are consumed silently.
    assign wrEn = (src == SRC_CLR) ||
                  (((src == SRC_WB) || (src == SRC_FIFO)) &&
                   (wrAddr != '0));

    always_comb begin
        stateNext   = state;
        clrAddrNext = clrAddr;
        unique case (state)
            ST_IDLE: begin
                if (bus.clr_start) begin
                    stateNext   = ST_CLEAR;
                    clrAddrNext = FirstAddr;
                end
            end
            ST_CLEAR: begin
                if (clrAddr == LastAddr) begin
                    stateNext = ST_DONE;
                end else begin
                    clrAddrNext = clrAddr + FirstAddr;
                end
            end
            ST_DONE: begin
                stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            clrAddr <= '0;
        end else begin
            state   <= stateNext;
            clrAddr <= clrAddrNext;
        end
    end

    // Address/data hold their last value while no write is issued.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rfWe     <= 1'b0;
            rfWrReg  <= '0;
            rfInData <= '0;
        end else begin
            rfWe <= wrEn;
            if (wrEn) begin
                rfWrReg  <= wrAddr;
                rfInData <= wrData;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wbLost <= 1'b0;
        end else if (bus.wb_we && busy) begin
            wbLost <= 1'b1;
        end
    end

    assign bus.dbg_ready  = !fifoFull;
    assign bus.clr_busy   = busy;
    assign bus.clr_done   = (state == ST_DONE);
    assign bus.pipe_stall = busy;
    assign bus.wb_lost    = wbLost;
    assign bus.rf_we      = rfWe;
    assign bus.rf_wr_reg  = rfWrReg;
    assign bus.rf_in_data = rfInData;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: vector table, directed clear/reset
// sequences and random traffic against a queue-based reference model.
module tb_regfile_port_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int FD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_port_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    regfile_port_ctrl #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .NUM_REGS   (NR),
        .FIFO_DEPTH (FD),
        .CLR_VALUE  (32'h0)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: a queue for the FIFO, an integer clear index
    // (0 = not clearing, 1..NR-1 = next register, NR = done cycle).
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    int            clrIdx;
    logic          mWe;
    logic [AW-1:0] mReg;
    logic [DW-1:0] mData;
    logic          mLost;

    task automatic modelReset();
        q.delete();
        clrIdx = 0;
        mWe    = 1'b0;
        mReg   = '0;
        mData  = '0;
        mLost  = 1'b0;
    endtask

    task automatic modelEdge();
        bit   pushOk = bus.dbg_valid && (q.size() < FD);
        ent_t e;
        mWe = 1'b0;
        if (clrIdx == 0) begin
            if (bus.wb_we) begin
                if (bus.wb_addr != 0) begin
                    mWe = 1'b1; mReg = bus.wb_addr; mData = bus.wb_data;
                end
            end else if (q.size() > 0) begin
                e = q.pop_front();
                if (e.a != 0) begin
                    mWe = 1'b1; mReg = e.a; mData = e.d;
                end
            end
            if (bus.clr_start) clrIdx = 1;
        end else begin
            if (bus.wb_we) mLost = 1'b1;
            if (clrIdx < NR) begin
                mWe = 1'b1; mReg = AW'(clrIdx); mData = '0;
                clrIdx++;
            end else begin
                clrIdx = 0;
            end
        end
        if (pushOk) q.push_back({bus.dbg_addr, bus.dbg_data});
    endtask

    task automatic checkAll(string tag);
        chk({tag, ".rf_we"},      bus.rf_we,      mWe);
        chk({tag, ".rf_wr_reg"},  bus.rf_wr_reg,  mReg);
        chk({tag, ".rf_in_data"}, bus.rf_in_data, mData);
        chk({tag, ".clr_busy"},   bus.clr_busy,   clrIdx != 0);
        chk({tag, ".clr_done"},   bus.clr_done,   clrIdx == NR);
        chk({tag, ".pipe_stall"}, bus.pipe_stall, clrIdx != 0);
        chk({tag, ".wb_lost"},    bus.wb_lost,    mLost);
        chk({tag, ".dbg_ready"},  bus.dbg_ready,  q.size() < FD);
    endtask

    task automatic step(string tag);
        @(posedge clk);
        modelEdge();
        #1;
        checkAll(tag);
    endtask

    task automatic idleIn();
        bus.wb_we     = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.dbg_valid = 1'b0;
        bus.dbg_addr  = '0;
        bus.dbg_data  = '0;
        bus.clr_start = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        idleIn();
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          dv;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        logic          eWe;
        logic [AW-1:0] eReg;
        logic [DW-1:0] eData;
        logic          eRdy;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int            n;
        int            wrA[$];
        int            wrD[$];
        int            wrC[$];
        int            doneCyc;
        int            doneCnt;
        bit            reached;
        logic [AW-1:0] dl[3];

        tbl[0] = '{1, 3,  32'h1234, 0, 0,  0,     1, 3,  32'h1234, 1};
        tbl[1] = '{1, 0,  32'hAA,   1, 0,  32'h55, 0, 3,  32'h1234, 1};
        tbl[2] = '{0, 0,  0,        0, 0,  0,     0, 3,  32'h1234, 1};
        tbl[3] = '{0, 0,  0,        1, 9,  32'h99, 0, 3,  32'h1234, 1};
        tbl[4] = '{0, 0,  0,        0, 0,  0,     1, 9,  32'h99,   1};
        tbl[5] = '{1, 2,  32'h22,   1, 8,  32'h88, 1, 2,  32'h22,   1};
        tbl[6] = '{1, 2,  32'h23,   1, 11, 32'hBB, 1, 2,  32'h23,   0};
        tbl[7] = '{0, 0,  0,        0, 0,  0,     1, 8,  32'h88,   1};
        tbl[8] = '{0, 0,  0,        0, 0,  0,     1, 11, 32'hBB,   1};

        idleIn();
        rst = 1'b1;
        #12;
        chk("rst.rf_we",      bus.rf_we,      0);
        chk("rst.rf_wr_reg",  bus.rf_wr_reg,  0);
        chk("rst.rf_in_data", bus.rf_in_data, 0);
        chk("rst.clr_busy",   bus.clr_busy,   0);
        chk("rst.clr_done",   bus.clr_done,   0);
        chk("rst.wb_lost",    bus.wb_lost,    0);
        chk("rst.dbg_ready",  bus.dbg_ready,  1);
        doReset();

        // Vector table
        for (int i = 0; i < 9; i++) begin
            bus.wb_we     = tbl[i].we;
            bus.wb_addr   = tbl[i].wa;
            bus.wb_data   = tbl[i].wd;
            bus.dbg_valid = tbl[i].dv;
            bus.dbg_addr  = tbl[i].da;
            bus.dbg_data  = tbl[i].dd;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d.rf_we", i),      bus.rf_we,      tbl[i].eWe);
            chk($sformatf("tbl%0d.rf_wr_reg", i),  bus.rf_wr_reg,  tbl[i].eReg);
            chk($sformatf("tbl%0d.rf_in_data", i), bus.rf_in_data, tbl[i].eData);
            chk($sformatf("tbl%0d.dbg_ready", i),  bus.dbg_ready,  tbl[i].eRdy);
        end

        // Writeback starving debug, FIFO filling, then draining in order
        doReset();
        dl = '{5'd5, 5'd6, 5'd7};
        n = 0;
        for (int c = 0; c < 10; c++) begin
            bit acc;
            bus.wb_we     = (c < 4);
            bus.wb_addr   = AW'(20 + c);
            bus.wb_data   = 32'hA000 + c;
            bus.dbg_valid = (n < 3);
            bus.dbg_addr  = dl[(n < 3) ? n : 0];
            bus.dbg_data  = 32'hD0 + n;
            acc = bus.dbg_valid && (q.size() < FD);
            step("t2");
            if (acc) n++;
            if (c == 1) chk("t2.ready_full", bus.dbg_ready, 0);
            if (bus.rf_we && bus.rf_wr_reg < 20) begin
                wrA.push_back(int'(bus.rf_wr_reg));
                wrC.push_back(c);
            end
        end
        idleIn();
        chk("t2.count", wrA.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t2.addr%0d", i),
                (wrA.size() > i) ? wrA[i] : -1, int'(dl[i]));
            chk($sformatf("t2.cyc%0d", i),
                (wrC.size() > i) ? wrC[i] : -1, 4 + i);
        end

        // Full clear with pushes, a lost writeback and an ignored restart
        doReset();
        wrA.delete(); wrD.delete(); wrC.delete();
        doneCyc = -1;
        doneCnt = 0;
        for (int c = 0; c < 41; c++) begin
            idleIn();
            bus.clr_start = (c == 0) || (c == 5);
            if (c == 2) begin
                bus.dbg_valid = 1'b1; bus.dbg_addr = 12; bus.dbg_data = 32'hC12;
            end
            if (c == 3) begin
                bus.dbg_valid = 1'b1; bus.dbg_addr = 13; bus.dbg_data = 32'hC13;
            end
            if (c == 10) begin
                bus.wb_we = 1'b1; bus.wb_addr = 4; bus.wb_data = 32'hBAD;
            end
            step("t4");
            if (bus.clr_done) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = c;
            end
            if (c == 1) chk("t4.pipe_stall", bus.pipe_stall, 1);
            if (c == 10) chk("t5.wb_lost_set", bus.wb_lost, 1);
            if (bus.rf_we) begin
                wrA.push_back(int'(bus.rf_wr_reg));
                wrD.push_back(int'(bus.rf_in_data));
                wrC.push_back(c);
            end
        end
        idleIn();
        chk("t4.done_cycle", doneCyc, 31);
        chk("t4.done_count", doneCnt, 1);
        chk("t4.writes", wrA.size(), 33);
        for (int i = 0; i < 33; i++) begin
            int ea, ed, ec;
            if (i < 31) begin ea = i + 1; ed = 0; ec = i + 1; end
            else if (i == 31) begin ea = 12; ed = 32'hC12; ec = 33; end
            else begin ea = 13; ed = 32'hC13; ec = 34; end
            chk($sformatf("t4.addr%0d", i), (wrA.size() > i) ? wrA[i] : -1, ea);
            chk($sformatf("t4.data%0d", i), (wrD.size() > i) ? wrD[i] : -1, ed);
            chk($sformatf("t4.cyc%0d", i),  (wrC.size() > i) ? wrC[i] : -1, ec);
        end
        chk("t5.wb_lost_sticky", bus.wb_lost, 1);
        doReset();
        chk("t5.wb_lost_reset", bus.wb_lost, 0);

        // Reset in the middle of a clear
        bus.clr_start = 1'b1;
        step("t6");
        bus.clr_start = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 40 && !reached; c++) begin
            step("t6");
            if (bus.rf_we && bus.rf_wr_reg == 10) reached = 1'b1;
        end
        chk("t6.reach_addr10", reached, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6.rf_we",      bus.rf_we,      0);
        chk("t6.rf_wr_reg",  bus.rf_wr_reg,  0);
        chk("t6.rf_in_data", bus.rf_in_data, 0);
        chk("t6.clr_busy",   bus.clr_busy,   0);
        chk("t6.pipe_stall", bus.pipe_stall, 0);
        chk("t6.clr_done",   bus.clr_done,   0);
        chk("t6.dbg_ready",  bus.dbg_ready,  1);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        doneCnt = 0;
        for (int c = 0; c < 40; c++) begin
            step("t6b");
            if (bus.clr_done) doneCnt++;
        end
        chk("t6.no_done", doneCnt, 0);

        // Random traffic against the model
        doReset();
        for (int c = 0; c < 600; c++) begin
            bus.wb_we     = ($urandom_range(0, 9) < 3);
            bus.wb_addr   = AW'($urandom_range(0, 31));
            bus.wb_data   = $urandom;
            bus.dbg_valid = $urandom_range(0, 1) == 1;
            bus.dbg_addr  = AW'($urandom_range(0, 31));
            bus.dbg_data  = $urandom;
            bus.clr_start = ($urandom_range(0, 79) == 0);
            step("rnd");
        end
        idleIn();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
